uart_rx_frame: RTL
==================

// Module: uart_rx_frame
// PURPOSE
//  UART receive framer; sits directly downstream of baud_gen (fractional-N tick generator).
//  - Synchronises rxd and detects the start-bit falling edge.
//  - Drives baud_en/baud_align so baud_gen ticks land mid-bit, then samples start/data/stop bits.
//  - Delivers bytes on a valid/ready interface and flags framing and overrun errors.
// PARAMETERS
//  DATA_BITS    8  data bits per frame, LSB first (legal 5..8)
//  SYNC_STAGES  2  rxd synchroniser flops (legal >=2)
//  PARITY_ODD   0  parity sense when UART_RX_PARITY_EN defined: 0=even, 1=odd
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          async active-low reset
//  rxd         in   1          serial line, async, idle high
//  baud_tick   in   1          1-cycle mid-bit strobe from baud_gen.tick
//  baud_en     out  1          to baud_gen.en; high while a frame is in progress
//  baud_align  out  1          to baud_gen.align; 1-cycle pulse at start-edge detect
//  rx_data     out  DATA_BITS  received byte; stable while rx_valid=1
//  rx_valid    out  1          byte available; held until rx_ready
//  rx_ready    in   1          consumer accepts when rx_valid&&rx_ready
//  frame_err   out  1          1-cycle pulse: stop bit sampled low
//  overrun     out  1          1-cycle pulse: frame completed while rx_valid&&!rx_ready
// BEHAVIOUR
//  Reset: all outputs 0; rx_data=0; FSM=IDLE; synchroniser flops preset to 1 (idle line).
//  rxd_s = last synchroniser stage; falling edge = rxd_s 1->0 (needs one extra flop for edge).
//  FSM: IDLE, START, DATA, [PARITY], STOP, BREAK. baud_en=1 in START..STOP, 0 in IDLE/BREAK.
//  IDLE: on falling edge -> baud_align=1 for that cycle, baud_en=1, go to START.
//  START: on baud_tick: rxd_s=0 -> DATA, bit_cnt=0; rxd_s=1 -> IDLE (glitch; no flags).
//  DATA: on baud_tick: shift rxd_s into MSB of shift reg (right-shift, LSB first), bit_cnt++.
//   After DATA_BITS ticks -> PARITY (macro defined) or STOP. bit_cnt width $clog2(DATA_BITS+1).
//  STOP: on baud_tick:
//   - rxd_s=1: if !rx_valid or rx_ready same cycle -> load rx_data, rx_valid=1 next cycle;
//     else overrun=1, new byte dropped, old byte retained. Then -> IDLE.
//   - rxd_s=0: frame_err=1, byte discarded, -> BREAK.
//  BREAK: wait for rxd_s=1 -> IDLE (a held-low line never yields a spurious frame).
//  Handshake: rx_valid clears the cycle after rx_valid&&rx_ready unless a new byte loads in
//   that same cycle (then stays 1 with new data). rx_valid never depends combinationally on rx_ready.
//  Latency: rx_valid rises 1 clk after the stop-bit baud_tick.
//  baud_tick ignored in IDLE/BREAK. A new falling edge is honoured the cycle IDLE is re-entered.
//  Async reset mid-frame: immediate return to reset state; partial byte lost, no flags.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: PARITY state after DATA; on baud_tick compare rxd_s against
//   ^data ^ PARITY_ODD. Mismatch -> extra output port parity_err (1 bit, 1-cycle pulse,
//   reset 0) and byte is discarded. Stop bit is still checked; frame_err takes precedence.
//  Not defined: no PARITY state, no parity_err port; frame = start + DATA_BITS + stop.
// TESTING (bench: uart_rx_frame + baud_gen, 25 MHz, 115200 baud, ~217 clk/bit)
//  1. Send 0x55, rx_ready=1 -> rx_valid 1 cycle, rx_data=0x55, no error flags.
//  2. Send 0xA3 then 0x3C back-to-back (1 stop bit), rx_ready=1 -> two valids, 0xA3 then 0x3C.
//  3. rxd low pulse of 40 clk while idle -> START rejects it; no rx_valid, FSM returns to IDLE.
//  4. Send 0x7E with stop bit low, then hold rxd low 1000 clk -> one frame_err, no rx_valid,
//     no further activity until rxd high; then 0x11 -> rx_data=0x11.
//  5. rx_ready=0; send 0x01 then 0x02 -> rx_valid held with 0x01, one overrun pulse; rx_ready=1 -> 0x01 consumed.
//  6. Assert rst_n=0 mid-data-bit of 0x5A, release, send 0xC3 -> only 0xC3 delivered;
//     with UART_RX_PARITY_EN, even parity, 0x07 with parity bit 0 -> parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer sitting behind a fractional-N baud_gen.
// Synchronises rxd, detects the start edge, steers baud_gen (en/align) so its
// ticks land mid-bit, then samples start/data/stop and hands bytes out on a
// valid/ready interface with framing/overrun flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 baud_align,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  // PARITY is only ever entered when parity checking is built in.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  // Reject illegal configurations at elaboration time.
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
    $error("uart_rx_frame: DATA_BITS must be 5..8");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_frame: SYNC_STAGES must be >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
  end

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   rxd_d;
  logic                   fall;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
`endif

  // Synchroniser preset to 1 so reset looks like an idle line (no false start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxd_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_d  <= rxd_s;
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign fall  = rxd_d & ~rxd_s;

  // Frame FSM with registered outputs and the output byte handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      baud_en    <= 1'b0;
      baud_align <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      baud_align <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Consumer takes the byte; a load in STOP below may re-assert it.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            baud_align <= 1'b1;
            baud_en    <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            if (!rxd_s) begin
              bit_cnt <= '0;
              state   <= DATA;
`ifdef UART_RX_PARITY_EN
              par_bad <= 1'b0;
`endif
            end else begin
              // Line back high at mid start bit: glitch, silently drop it.
              baud_en <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift   <= {rxd_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            par_bad <= rxd_s ^ (^shift) ^ PARITY_ODD[0];
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            baud_en <= 1'b0;
            if (!rxd_s) begin
              // Framing error wins over parity; wait out a held-low line.
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err <= 1'b1;
              end else
`endif
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        BREAK: begin
          if (rxd_s) state <= IDLE;
        end
        default: begin
          baud_en <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
